// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the 16-bit TSC core.
// Decodes opcode/func_code/bcond into datapath strobes. Memory accesses
// (fetch and data) finish either after MEM_LAT cycles or on mem_ready.
// HALT is sticky until reset, and num_inst counts retired instructions.
//
// state | meaning
// ------+-----------------------------------------------
// IF    | instruction fetch, wait for access done
// ID    | decode, ALUOut <= PC+1
// EX1   | execute / branch compare / link write
// EX2   | PC update for taken branch or jump
// MEM   | data load/store, wait for access done
// WB    | register write back, PC <= PC+1
// HALT  | halted until reset
module mc_control_fsm #(
  parameter int MEM_MODE = 0,
  parameter int MEM_LAT  = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic [5:0]       func_code,
  input  logic             bcond,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             pc_to_reg,
  output logic             pc_src,
  output logic [1:0]       reg_write_dest,
  output logic             alu_src_A,
  output logic [1:0]       alu_src_B,
  output logic [1:0]       alu_op,
  output logic             wwd,
  output logic             new_inst,
  output logic             halt,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] num_inst
);

  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_RTY = 4'd15;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX1  = 3'd2,
    S_EX2  = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_cnt;
  logic       halt_q;
  logic       fetch_cont;
  logic       access, cnt_done, done;

  logic pc_write_i, mem_read_i, mem_write_i, ir_write_i, reg_write_i, wwd_i;

  logic is_rtype, is_ralu, is_wwd, is_jpr, is_jrl, is_hlt;
  logic is_imm, is_lwd, is_swd, is_jmp, is_jal, is_br;

  assign is_rtype = (opcode == OP_RTY);
  assign is_ralu  = is_rtype && (func_code[5:3] == 3'b000);
  assign is_wwd   = is_rtype && (func_code == FN_WWD);
  assign is_jpr   = is_rtype && (func_code == FN_JPR);
  assign is_jrl   = is_rtype && (func_code == FN_JRL);
  assign is_hlt   = is_rtype && (func_code == FN_HLT);
  assign is_imm   = (opcode == OP_ADI) || (opcode == OP_ORI) || (opcode == OP_LHI);
  assign is_lwd   = (opcode == OP_LWD);
  assign is_swd   = (opcode == OP_SWD);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_jal   = (opcode == OP_JAL);
  assign is_br    = (opcode <= 4'd3);

  // mem_ready only matters while a fetch or data access is in flight
  assign access   = (state_q == S_IF) || (state_q == S_MEM);
  assign cnt_done = (wait_cnt == 4'(MEM_LAT - 1));
  assign done     = access && ((MEM_MODE == 1) ? mem_ready : cnt_done);

  // State register, access timer, retire counter and sticky halt flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IF;
      wait_cnt   <= '0;
      num_inst   <= '0;
      halt_q     <= 1'b0;
      fetch_cont <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((MEM_MODE == 0) && access && !done) wait_cnt <= wait_cnt + 4'd1;
      else                                   wait_cnt <= '0;
      if ((state_d == S_IF && state_q != S_IF) || (state_d == S_HALT && state_q != S_HALT))
        num_inst <= num_inst + CNT_W'(1);
      if (state_d == S_HALT) halt_q <= 1'b1;
      fetch_cont <= (state_q == S_IF) && (state_d == S_IF);
    end
  end

  // Next-state and strobe decode; everything defaults to 0 each cycle
  always_comb begin
    state_d        = S_IF;
    pc_write_i     = 1'b0;
    pc_write_cond  = 1'b0;
    i_or_d         = 1'b0;
    mem_read_i     = 1'b0;
    mem_write_i    = 1'b0;
    ir_write_i     = 1'b0;
    mem_to_reg     = 1'b0;
    reg_write_i    = 1'b0;
    pc_to_reg      = 1'b0;
    pc_src         = 1'b0;
    reg_write_dest = 2'b00;
    alu_src_A      = 1'b0;
    alu_src_B      = 2'b00;
    alu_op         = 2'b00;
    wwd_i          = 1'b0;
    new_inst       = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read_i = 1'b1;
        new_inst   = !fetch_cont;
        if (done) begin
          ir_write_i = 1'b1;
          state_d    = S_ID;
        end else begin
          state_d = S_IF;
        end
      end
      S_ID: begin
        alu_src_B = 2'b01;
        state_d   = is_hlt ? S_HALT : S_EX1;
      end
      S_EX1: begin
        if (is_ralu) begin
          alu_src_A = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_WB;
        end else if (is_imm) begin
          alu_src_A = 1'b1;
          alu_src_B = 2'b10;
          alu_op    = 2'b10;
          state_d   = S_WB;
        end else if (is_lwd || is_swd) begin
          alu_src_A = 1'b1;
          alu_src_B = 2'b10;
          state_d   = S_MEM;
        end else if (is_jmp || is_jal) begin
          alu_src_B = 2'b10;
          alu_op    = 2'b10;
          state_d   = S_EX2;
          if (is_jal) begin
            reg_write_i    = 1'b1;
            reg_write_dest = 2'b10;
            pc_to_reg      = 1'b1;
          end
        end else if (is_jpr || is_jrl) begin
          alu_src_A = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_EX2;
          if (is_jrl) begin
            reg_write_i    = 1'b1;
            reg_write_dest = 2'b10;
            pc_to_reg      = 1'b1;
          end
        end else if (is_br) begin
          alu_src_A = 1'b1;
          alu_op    = 2'b01;
          if (bcond) begin
            state_d = S_EX2;
          end else begin
            pc_write_i = 1'b1;
            pc_src     = 1'b1;
            state_d    = S_IF;
          end
        end else begin
          // WWD and any undefined encoding both just step PC from ALUOut
          wwd_i      = is_wwd;
          pc_write_i = 1'b1;
          pc_src     = 1'b1;
          state_d    = S_IF;
        end
      end
      S_EX2: begin
        pc_write_i = 1'b1;
        state_d    = S_IF;
        if (is_br) begin
          alu_src_B = 2'b10;
          alu_op    = 2'b10;
        end else begin
          pc_src = 1'b1;
        end
      end
      S_MEM: begin
        i_or_d      = 1'b1;
        mem_read_i  = is_lwd;
        mem_write_i = is_swd;
        if (!(is_lwd || is_swd)) begin
          state_d = S_IF;
        end else if (!done) begin
          state_d = S_MEM;
        end else if (is_lwd) begin
          state_d = S_WB;
        end else begin
          pc_write_i = 1'b1;
          alu_src_B  = 2'b01;
          state_d    = S_IF;
        end
      end
      S_WB: begin
        reg_write_i    = 1'b1;
        reg_write_dest = (is_imm || is_lwd) ? 2'b01 : 2'b00;
        mem_to_reg     = is_lwd;
        pc_write_i     = 1'b1;
        alu_src_B      = 2'b01;
        state_d        = S_IF;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // Reset masks every write/read strobe so an aborted access cannot complete
  assign pc_write  = pc_write_i  & ~reset;
  assign mem_read  = mem_read_i  & ~reset;
  assign mem_write = mem_write_i & ~reset;
  assign ir_write  = ir_write_i  & ~reset;
  assign reg_write = reg_write_i & ~reset;
  assign wwd       = wwd_i       & ~reset;
  assign halt      = halt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: dut0 uses fixed latency (MEM_LAT=2, CNT_W=4),
// dut1 uses the mem_ready handshake. Each instruction is expanded by a
// model into its expected per-cycle output words; one process compares.
module tb_mc_control_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic pcw, pcwc, iod, mr, mw, irw, m2r, rw, p2r, psrc;
    logic [1:0] dest;
    logic a;
    logic [1:0] b;
    logic [1:0] op;
    logic wwd, ni, hlt;
  } outs_t;

  localparam int K_ALU = 0, K_IMM = 1, K_LWD = 2, K_SWD = 3, K_JMP = 4, K_JAL = 5;
  localparam int K_JPR = 6, K_JRL = 7, K_BR = 8, K_WWD = 9, K_HLT = 10, K_NOP = 11;

  logic clk = 1'b0;
  logic rst0, rst1;
  logic [3:0] opcode;
  logic [5:0] func_code;
  logic bcond, mem_ready;

  logic d0_pcw, d0_pcwc, d0_iod, d0_mr, d0_mw, d0_irw, d0_m2r, d0_rw, d0_p2r, d0_psrc;
  logic [1:0] d0_dest, d0_b, d0_op;
  logic d0_a, d0_wwd, d0_ni, d0_hlt;
  logic [2:0] d0_state;
  logic [3:0] d0_num;

  logic d1_pcw, d1_pcwc, d1_iod, d1_mr, d1_mw, d1_irw, d1_m2r, d1_rw, d1_p2r, d1_psrc;
  logic [1:0] d1_dest, d1_b, d1_op;
  logic d1_a, d1_wwd, d1_ni, d1_hlt;
  logic [2:0] d1_state;
  logic [15:0] d1_num;

  outs_t act0, act1, exp_cur;
  outs_t exp_q[$];
  bit    rdy_q[$];
  bit    exp_on = 1'b0;
  int    sel = 0;
  int    retired = 0;
  int    n_pass = 0;
  int    n_total = 0;
  int    cyc_idx = 0;
  string cur_name = "idle";

  mc_control_fsm #(.MEM_MODE(0), .MEM_LAT(2), .CNT_W(4)) dut0 (
    .clk(clk), .reset(rst0), .opcode(opcode), .func_code(func_code), .bcond(bcond),
    .mem_ready(mem_ready), .pc_write(d0_pcw), .pc_write_cond(d0_pcwc), .i_or_d(d0_iod),
    .mem_read(d0_mr), .mem_write(d0_mw), .ir_write(d0_irw), .mem_to_reg(d0_m2r),
    .reg_write(d0_rw), .pc_to_reg(d0_p2r), .pc_src(d0_psrc), .reg_write_dest(d0_dest),
    .alu_src_A(d0_a), .alu_src_B(d0_b), .alu_op(d0_op), .wwd(d0_wwd), .new_inst(d0_ni),
    .halt(d0_hlt), .state(d0_state), .num_inst(d0_num));

  mc_control_fsm #(.MEM_MODE(1), .MEM_LAT(2), .CNT_W(16)) dut1 (
    .clk(clk), .reset(rst1), .opcode(opcode), .func_code(func_code), .bcond(bcond),
    .mem_ready(mem_ready), .pc_write(d1_pcw), .pc_write_cond(d1_pcwc), .i_or_d(d1_iod),
    .mem_read(d1_mr), .mem_write(d1_mw), .ir_write(d1_irw), .mem_to_reg(d1_m2r),
    .reg_write(d1_rw), .pc_to_reg(d1_p2r), .pc_src(d1_psrc), .reg_write_dest(d1_dest),
    .alu_src_A(d1_a), .alu_src_B(d1_b), .alu_op(d1_op), .wwd(d1_wwd), .new_inst(d1_ni),
    .halt(d1_hlt), .state(d1_state), .num_inst(d1_num));

  assign act0 = {d0_state, d0_pcw, d0_pcwc, d0_iod, d0_mr, d0_mw, d0_irw, d0_m2r, d0_rw,
                 d0_p2r, d0_psrc, d0_dest, d0_a, d0_b, d0_op, d0_wwd, d0_ni, d0_hlt};
  assign act1 = {d1_state, d1_pcw, d1_pcwc, d1_iod, d1_mr, d1_mw, d1_irw, d1_m2r, d1_rw,
                 d1_p2r, d1_psrc, d1_dest, d1_a, d1_b, d1_op, d1_wwd, d1_ni, d1_hlt};

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s (%s) actual=%h required=%h", nm, cur_name, act, req);
  endfunction

  function automatic int classify(input logic [3:0] op, input logic [5:0] fn);
    if (op <= 4'd3) return K_BR;
    if (op >= 4'd4 && op <= 4'd6) return K_IMM;
    if (op == 4'd7) return K_LWD;
    if (op == 4'd8) return K_SWD;
    if (op == 4'd9) return K_JMP;
    if (op == 4'd10) return K_JAL;
    if (op != 4'd15) return K_NOP;
    if (fn <= 6'd7) return K_ALU;
    if (fn == 6'd25) return K_JPR;
    if (fn == 6'd26) return K_JRL;
    if (fn == 6'd28) return K_WWD;
    if (fn == 6'd29) return K_HLT;
    return K_NOP;
  endfunction

  function automatic outs_t blank(input int st);
    outs_t o;
    o = '0;
    o.st = 3'(st);
    return o;
  endfunction

  // Reset forces the six write/read strobes low whatever the state wants
  function automatic outs_t gate(input outs_t i);
    outs_t o;
    o = i;
    o.pcw = 0; o.irw = 0; o.rw = 0; o.mr = 0; o.mw = 0; o.wwd = 0;
    return o;
  endfunction

  function automatic void push(input outs_t o, input bit rdy);
    exp_q.push_back(o);
    rdy_q.push_back(rdy);
  endfunction

  // Expand one instruction into the cycle-by-cycle outputs it must produce
  function automatic void plan(input logic [3:0] op, input logic [5:0] fn, input logic bc,
                               input int if_cyc, input int mem_cyc);
    outs_t o;
    int k;
    exp_q.delete();
    rdy_q.delete();
    k = classify(op, fn);
    for (int c = 0; c < if_cyc; c++) begin
      o = blank(0); o.mr = 1; o.ni = (c == 0); o.irw = (c == if_cyc - 1);
      push(o, c == if_cyc - 1);
    end
    o = blank(1); o.b = 2'b01; push(o, 1);
    if (k == K_HLT) begin
      for (int c = 0; c < 20; c++) begin
        o = blank(6); o.hlt = 1; push(o, 1);
      end
    end else if (k == K_ALU || k == K_IMM) begin
      o = blank(2); o.a = 1; o.op = 2'b10; if (k == K_IMM) o.b = 2'b10; push(o, 1);
      o = blank(5); o.rw = 1; o.pcw = 1; o.b = 2'b01; if (k == K_IMM) o.dest = 2'b01; push(o, 1);
    end else if (k == K_LWD || k == K_SWD) begin
      o = blank(2); o.a = 1; o.b = 2'b10; push(o, 1);
      for (int c = 0; c < mem_cyc; c++) begin
        o = blank(4); o.iod = 1;
        if (k == K_LWD) o.mr = 1; else o.mw = 1;
        if (k == K_SWD && c == mem_cyc - 1) begin o.pcw = 1; o.b = 2'b01; end
        push(o, c == mem_cyc - 1);
      end
      if (k == K_LWD) begin
        o = blank(5); o.rw = 1; o.dest = 2'b01; o.m2r = 1; o.pcw = 1; o.b = 2'b01; push(o, 1);
      end
    end else if (k == K_JMP || k == K_JAL || k == K_JPR || k == K_JRL) begin
      o = blank(2); o.op = 2'b10;
      if (k == K_JMP || k == K_JAL) o.b = 2'b10; else o.a = 1;
      if (k == K_JAL || k == K_JRL) begin o.rw = 1; o.dest = 2'b10; o.p2r = 1; end
      push(o, 1);
      o = blank(3); o.pcw = 1; o.psrc = 1; push(o, 1);
    end else if (k == K_BR) begin
      o = blank(2); o.a = 1; o.op = 2'b01;
      if (!bc) begin o.pcw = 1; o.psrc = 1; end
      push(o, 1);
      if (bc) begin
        o = blank(3); o.pcw = 1; o.b = 2'b10; o.op = 2'b10; push(o, 1);
      end
    end else begin
      o = blank(2); o.pcw = 1; o.psrc = 1; o.wwd = (k == K_WWD); push(o, 1);
    end
  endfunction

  function automatic logic [31:0] cur_num();
    return (sel == 0) ? 32'(d0_num) : 32'(d1_num);
  endfunction

  function automatic logic [31:0] req_num();
    return (sel == 0) ? 32'(retired % 16) : 32'(retired % 65536);
  endfunction

  task automatic set_rst(input logic v);
    if (sel == 0) rst0 = v; else rst1 = v;
  endtask

  // Called at the start of a cycle; leaves the DUT in its first IF cycle
  task automatic do_reset();
    exp_on = 1'b0;
    set_rst(1'b1);
    @(posedge clk); #1;
    set_rst(1'b0);
    retired = 0;
  endtask

  task automatic exec(input string nm, input logic [3:0] op, input logic [5:0] fn, input logic bc,
                      input int if_cyc, input int mem_cyc, input int abort_at);
    plan(op, fn, bc, if_cyc, mem_cyc);
    cur_name = nm;
    opcode = op; func_code = fn; bcond = bc;
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = rdy_q[i];
      cyc_idx = i;
      if (i == abort_at) begin
        set_rst(1'b1);
        exp_cur = gate(exp_q[i]);
        exp_on = 1'b1;
        @(posedge clk); #1;
        set_rst(1'b0);
        exp_on = 1'b0;
        retired = 0;
        return;
      end
      exp_cur = exp_q[i];
      exp_on = 1'b1;
      @(posedge clk); #1;
    end
    exp_on = 1'b0;
    retired++;
    check("num_inst", cur_num(), req_num());
  endtask

  // Cycle compare of the selected DUT against the model, away from the edge
  always @(negedge clk) begin
    if (exp_on) begin
      if (sel == 0) check($sformatf("cycle%0d", cyc_idx), 32'(act0), 32'(exp_cur));
      else          check($sformatf("cycle%0d", cyc_idx), 32'(act1), 32'(exp_cur));
    end
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    opcode = 4'd0; func_code = 6'd0; bcond = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ---- dut0: fixed latency 2, 4-bit counter ----
    sel = 0;
    do_reset();
    cur_name = "reset";
    check("rst_state", 32'(d0_state), 32'd0);
    check("rst_halt", 32'(d0_hlt), 32'd0);
    check("rst_num", 32'(d0_num), 32'd0);
    check("rst_new_inst", 32'(d0_ni), 32'd1);

    plan(4'd15, 6'd0, 1'b0, 2, 2);
    cur_name = "model_add";
    check("add_len", 32'(exp_q.size()), 32'd5);
    check("add_wb", 32'(exp_q[4]), 32'({3'd5, 10'b1000000100, 2'b00, 1'b0, 2'b01, 2'b00, 3'b000}));

    exec("ADD", 4'd15, 6'd0, 1'b0, 2, 2, -1);
    check("add_num_lit", 32'(d0_num), 32'd1);
    exec("ORI", 4'd5, 6'd0, 1'b0, 2, 2, -1);
    exec("BEQ_nt", 4'd1, 6'd0, 1'b0, 2, 2, -1);
    exec("BEQ_t", 4'd1, 6'd0, 1'b1, 2, 2, -1);
    exec("JAL", 4'd10, 6'd0, 1'b0, 2, 2, -1);
    exec("JRL", 4'd15, 6'd26, 1'b0, 2, 2, -1);
    exec("JMP", 4'd9, 6'd0, 1'b0, 2, 2, -1);
    exec("NOP_op12", 4'd12, 6'd0, 1'b0, 2, 2, -1);
    exec("SWD", 4'd8, 6'd0, 1'b0, 2, 2, -1);
    exec("LWD", 4'd7, 6'd0, 1'b0, 2, 2, -1);
    exec("WWD", 4'd15, 6'd28, 1'b0, 2, 2, -1);

    do_reset();
    for (int n = 0; n < 16; n++) exec("WWD_wrap", 4'd15, 6'd28, 1'b0, 2, 2, -1);
    cur_name = "wrap";
    check("wrap_num_lit", 32'(d0_num), 32'd0);

    exec("SWD_abort", 4'd8, 6'd0, 1'b0, 2, 2, 4);
    cur_name = "after_abort";
    check("abort_state", 32'(d0_state), 32'd0);
    check("abort_num", 32'(d0_num), 32'd0);

    exec("HLT", 4'd15, 6'd29, 1'b0, 2, 2, -1);
    cur_name = "halted";
    check("halt_state_lit", 32'(d0_state), 32'd6);
    check("halt_flag_lit", 32'(d0_hlt), 32'd1);
    do_reset();
    cur_name = "halt_reset";
    check("hrst_state", 32'(d0_state), 32'd0);
    check("hrst_halt", 32'(d0_hlt), 32'd0);
    check("hrst_num", 32'(d0_num), 32'd0);

    // ---- dut1: mem_ready handshake ----
    rst0 = 1'b1;
    sel = 1;
    do_reset();
    exec("LWD_rdy", 4'd7, 6'd0, 1'b0, 2, 4, -1);
    exec("ADD_rdy", 4'd15, 6'd1, 1'b0, 1, 1, -1);
    exec("SWD_rdy", 4'd8, 6'd0, 1'b0, 3, 1, -1);
    exec("JPR_rdy", 4'd15, 6'd25, 1'b0, 1, 1, -1);
    exec("BNE_rdy", 4'd0, 6'd0, 1'b1, 2, 1, -1);
    cur_name = "rdy_end";
    check("rdy_num_lit", 32'(d1_num), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Parametrised multicycle control FSM for the 16-bit TSC core. Next generation of the existing multicycle control unit.
- Drives datapath strobes (PC, IR, memory, register file, ALU muxes) from opcode, func_code and bcond.
- New over the previous unit: configurable memory timing (fixed latency or ready handshake), a sticky halt state, a retired-instruction counter, and reset-gated strobes.

Parameters:
- MEM_MODE, 0: 0 = fixed latency of MEM_LAT cycles; 1 = wait for mem_ready.
- MEM_LAT, 2: memory access length in cycles when MEM_MODE=0; legal range 1..15.
- CNT_W, 16: width of num_inst counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  IR[15:12]; encodings from opcodes.v.
- func_code  in  6  IR[5:0].
- bcond  in  1  1 = branch condition true (taken), valid in EX1.
- mem_ready  in  1  memory completion; used only when MEM_MODE=1.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, pc_to_reg, pc_src  out  1 each  datapath strobes.
- reg_write_dest  out  2  00 rd, 01 rt, 10 $2.
- alu_src_A  out  1  0 PC, 1 reg A.
- alu_src_B  out  2  00 reg B, 01 const 1, 10 immediate.
- alu_op  out  2  00 ADD, 01 SUB, 10 decode by func/opcode.
- wwd  out  1  WWD output latch enable.
- new_inst  out  1  first cycle of a fetch.
- halt  out  1  sticky halted flag.
- state  out  3  current state, for debug.
- num_inst  out  CNT_W  retired-instruction count.

Behaviour:
- State encoding: IF=0, ID=1, EX1=2, EX2=3, MEM=4, WB=5, HALT=6. Codes 7 and any other illegal value go to IF next cycle.
- Reset: state<=IF, wait counter<=0, num_inst<=0, halt<=0.
  - While reset=1, all write/read strobes are forced to 0 (pc_write, ir_write, reg_write, mem_read, mem_write, wwd).
  - Reset mid-access aborts the access; no write completes.
- Defaults in every state: all strobes 0, pc_write_cond=0, mux selects 0.
- Access completion ("done"):
  - MEM_MODE=0: done when wait_cnt==MEM_LAT-1. wait_cnt increments each access cycle and clears on done.
  - MEM_MODE=1: done in the first cycle mem_ready=1 while a request is asserted. mem_ready outside IF/MEM is ignored.
- IF:
  - mem_read=1, i_or_d=0; new_inst=1 only in the first IF cycle.
  - On done: ir_write=1, next ID. Otherwise stay in IF.
- ID:
  - ALU computes PC+1 (A=PC, B=01, ADD) into ALUOut.
  - If HLT: next HALT. Otherwise next EX1.
- EX1:
  - R-type: A=reg, B=reg, op=10, next WB.
  - ADI/ORI/LHI: A=reg, B=imm, op=10, next WB.
  - LWD/SWD: A=reg, B=imm, ADD, next MEM.
  - JMP/JAL: A=PC, B=imm, op=10, next EX2.
  - JPR/JRL: A=reg, op=10, next EX2.
  - JAL/JRL: also reg_write=1, dest=10, pc_to_reg=1 (stores PC+1 in $2).
  - Branch: A=reg, B=reg, SUB.
    - bcond=1: next EX2.
    - bcond=0: pc_write=1, pc_src=1 (ALUOut=PC+1), next IF.
  - WWD: wwd=1, pc_write=1, pc_src=1, next IF.
- EX2:
  - pc_write=1, next IF.
  - Branch: A=PC, B=imm, op=10, pc_src=0.
  - Jump: pc_src=1.
- MEM:
  - i_or_d=1; mem_read (LWD) or mem_write (SWD) held until done.
  - Load done: next WB.
  - Store done: pc_write=1, A=PC, B=01, ADD, pc_src=0, next IF.
- WB:
  - reg_write=1; dest=01 for ADI/ORI/LHI/LWD, else 00; mem_to_reg=1 for LWD.
  - PC<=PC+1 via ALU (pc_write=1, pc_src=0); next IF.
- HALT: halt=1, all strobes 0, remain in HALT until reset.
- num_inst:
  - Increments by 1 on every transition into IF from a non-IF state, and on entry to HALT.
  - Wraps modulo 2^CNT_W.
- Undefined opcode/func: treated as a NOP. Goes ID -> EX1 -> IF with pc_write=1, pc_src=1 in EX1.

Test Plan:
- MEM_MODE=0, MEM_LAT=2; ADD: states IF,IF,ID,EX1,WB,IF. ir_write in the 2nd IF cycle. reg_write and dest=00 in WB. num_inst=1.
- MEM_MODE=1, LWD with mem_ready delayed 3 cycles in MEM: mem_read held 4 cycles. Then WB with mem_to_reg=1, dest=01.
- BEQ: bcond=0 gives pc_write in EX1, next IF, no EX2. bcond=1 gives EX2 with pc_src=0, B=10.
- JAL: EX1 asserts reg_write, dest=10, pc_to_reg=1. EX2 asserts pc_write, pc_src=1.
- HLT: state=6, halt=1 held 20 cycles, no strobes. reset=1 for one cycle restores IF, halt=0, num_inst=0.
- CNT_W=4, 16 NOP-class WWD instructions: num_inst wraps to 0. reset asserted during SWD MEM: mem_write=0 in that cycle, state=IF next.
